// File: rtl/hpdmc_pkg.sv
// Shared HPDMC definitions: init FSM states, SDRAM command encodings and
// mode-register field values.
package hpdmc_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP      = 4'd0,
        ST_CKEON      = 4'd1,
        ST_PRE1       = 4'd2,
        ST_EMRS       = 4'd3,
        ST_MRS_DLLRST = 4'd4,
        ST_PRE2       = 4'd5,
        ST_AREF1      = 4'd6,
        ST_AREF2      = 4'd7,
        ST_MRS        = 4'd8,
        ST_DLLWAIT    = 4'd9,
        ST_DONE       = 4'd10
    } hpdmc_state_t;

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // Mode register fields
    localparam logic [2:0]  MRS_BL4    = 3'b010;
    localparam logic [2:0]  MRS_CL2    = 3'b010;
    localparam logic [2:0]  MRS_CL3    = 3'b011;
    localparam logic [12:0] ADR_PREALL = 13'd1024;
    localparam logic [1:0]  BA_EMRS    = 2'b01;

    // MRS word: burst length 4, sequential, CAS latency, optional DLL reset
    function automatic logic [12:0] mrs_word(input logic cl3, input logic dll_rst);
        return {4'b0000, dll_rst, 1'b0, (cl3 ? MRS_CL3 : MRS_CL2), 1'b0, MRS_BL4};
    endfunction

endpackage

// File: rtl/hpdmc_downcounter.sv
// 16-bit loadable down-counter; done is high while the count is zero.
module hpdmc_downcounter #(
    parameter logic [15:0] rst_val = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        en,
    output logic        done
);

    logic [15:0] count;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= rst_val;
        else if (load)
            count <= value;
        else if (en && count != 16'd0)
            count <= count - 16'd1;
    end

    assign done = (count == 16'd0);

endmodule

// File: rtl/hpdmc_initseq.sv
// DDR SDRAM power-up init sequencer; owns the command bus until init_done,
// then passes the scheduler's bus straight through.
module hpdmc_initseq
    import hpdmc_pkg::*;
#(
    parameter int unsigned init_wait = 20000,
    parameter int unsigned dll_wait  = 200
) (
    input  logic        sys_clk,
    input  logic        sdram_rst_n,
    input  logic        init_restart,
    input  logic [2:0]  tim_rp,
    input  logic [1:0]  tim_mrd,
    input  logic [3:0]  tim_rfc,
    input  logic        tim_cas,
    input  logic        sched_cs_n,
    input  logic        sched_we_n,
    input  logic        sched_cas_n,
    input  logic        sched_ras_n,
    input  logic [12:0] sched_adr,
    input  logic [1:0]  sched_ba,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_we_n,
    output logic        sdram_cas_n,
    output logic        sdram_ras_n,
    output logic [12:0] sdram_adr,
    output logic [1:0]  sdram_ba,
    output logic        init_done
);

    hpdmc_state_t state, state_nx;
    logic [3:0]   cmd, cmd_nx;
    logic [12:0]  adr, adr_nx;
    logic [1:0]   ba, ba_nx;
    logic         cke_nx, done_nx;
    logic         cnt_load, cnt_dec, cnt_done;
    logic [15:0]  cnt_val;

    // Counter resets to the power-up wait so PWRUP needs no load cycle.
    hpdmc_downcounter #(
        .rst_val (16'(init_wait))
    ) u_cnt (
        .clk   (sys_clk),
        .rst_n (sdram_rst_n),
        .load  (cnt_load),
        .value (cnt_val),
        .en    (cnt_dec),
        .done  (cnt_done)
    );

    // State and registered init command/address/bank/CKE.
    always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state     <= ST_PWRUP;
            cmd       <= CMD_DESEL;
            adr       <= 13'd0;
            ba        <= 2'd0;
            sdram_cke <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd       <= cmd_nx;
            adr       <= adr_nx;
            ba        <= ba_nx;
            sdram_cke <= cke_nx;
            init_done <= done_nx;
        end
    end

    // Next state: a state's command is issued on entry together with the
    // counter load; the state then idles until the counter reads zero.
    always_comb begin
        state_nx = state;
        cmd_nx   = sdram_cke ? CMD_NOP : CMD_DESEL;
        adr_nx   = 13'd0;
        ba_nx    = 2'd0;
        cke_nx   = sdram_cke;
        done_nx  = init_done;
        cnt_load = 1'b0;
        cnt_val  = 16'd0;
        cnt_dec  = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (cnt_done) begin
                    state_nx = ST_CKEON;
                    cke_nx   = 1'b1;
                    cmd_nx   = CMD_NOP;
                end else
                    cnt_dec = 1'b1;
            end
            ST_CKEON: begin
                state_nx = ST_PRE1;
                cmd_nx   = CMD_PRE;
                adr_nx   = ADR_PREALL;
                cnt_load = 1'b1;
                cnt_val  = {13'd0, tim_rp};
            end
            ST_PRE1: begin
                if (cnt_done) begin
                    state_nx = ST_EMRS;
                    cmd_nx   = CMD_MRS;
                    ba_nx    = BA_EMRS;
                    cnt_load = 1'b1;
                    cnt_val  = {14'd0, tim_mrd};
                end else
                    cnt_dec = 1'b1;
            end
            ST_EMRS: begin
                if (cnt_done) begin
                    state_nx = ST_MRS_DLLRST;
                    cmd_nx   = CMD_MRS;
                    adr_nx   = mrs_word(tim_cas, 1'b1);
                    cnt_load = 1'b1;
                    cnt_val  = {14'd0, tim_mrd};
                end else
                    cnt_dec = 1'b1;
            end
            ST_MRS_DLLRST: begin
                if (cnt_done) begin
                    state_nx = ST_PRE2;
                    cmd_nx   = CMD_PRE;
                    adr_nx   = ADR_PREALL;
                    cnt_load = 1'b1;
                    cnt_val  = {13'd0, tim_rp};
                end else
                    cnt_dec = 1'b1;
            end
            ST_PRE2: begin
                if (cnt_done) begin
                    state_nx = ST_AREF1;
                    cmd_nx   = CMD_AREF;
                    cnt_load = 1'b1;
                    cnt_val  = {12'd0, tim_rfc};
                end else
                    cnt_dec = 1'b1;
            end
            ST_AREF1: begin
                if (cnt_done) begin
                    state_nx = ST_AREF2;
                    cmd_nx   = CMD_AREF;
                    cnt_load = 1'b1;
                    cnt_val  = {12'd0, tim_rfc};
                end else
                    cnt_dec = 1'b1;
            end
            ST_AREF2: begin
                if (cnt_done) begin
                    state_nx = ST_MRS;
                    cmd_nx   = CMD_MRS;
                    adr_nx   = mrs_word(tim_cas, 1'b0);
                    cnt_load = 1'b1;
                    cnt_val  = 16'(dll_wait);
                end else
                    cnt_dec = 1'b1;
            end
            // MRS and DLLWAIT share the same DLL-lock countdown.
            ST_MRS, ST_DLLWAIT: begin
                if (cnt_done) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = ST_DLLWAIT;
                    cnt_dec  = 1'b1;
                end
            end
            ST_DONE: begin
                // Re-run skips power-up: CKE stays high, PRE1 follows after one NOP.
                if (init_restart) begin
                    state_nx = ST_CKEON;
                    done_nx  = 1'b0;
                end
            end
            default: state_nx = ST_PWRUP;
        endcase
    end

    assign sdram_cs_n  = init_done ? sched_cs_n  : cmd[3];
    assign sdram_ras_n = init_done ? sched_ras_n : cmd[2];
    assign sdram_cas_n = init_done ? sched_cas_n : cmd[1];
    assign sdram_we_n  = init_done ? sched_we_n  : cmd[0];
    assign sdram_adr   = init_done ? sched_adr   : adr;
    assign sdram_ba    = init_done ? sched_ba    : ba;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// Self-checking bench for hpdmc_initseq: a cycle-by-cycle expectation list is
// built from the command list and delays, then compared against the DUT.
module tb_hpdmc_initseq;

    localparam int IW = 16;
    localparam int DW = 200;

    localparam logic [3:0] C_DESEL = 4'b1111;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_AREF  = 4'b0001;
    localparam logic [3:0] C_MRS   = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_restart = 1'b0;
    logic [2:0]  tim_rp = '0;
    logic [1:0]  tim_mrd = '0;
    logic [3:0]  tim_rfc = '0;
    logic        tim_cas = 1'b0;
    logic        sched_cs_n = 1'b1, sched_we_n = 1'b1, sched_cas_n = 1'b1, sched_ras_n = 1'b1;
    logic [12:0] sched_adr = '0;
    logic [1:0]  sched_ba = '0;
    logic        sdram_cke, sdram_cs_n, sdram_we_n, sdram_cas_n, sdram_ras_n, init_done;
    logic [12:0] sdram_adr;
    logic [1:0]  sdram_ba;

    int n_assert = 0;
    int n_fail   = 0;
    int rise;

    typedef struct {
        bit         cke;
        bit         done;
        logic [3:0] cmd;
        bit         is_cmd;
        logic [12:0] adr;
        logic [1:0] ba;
    } exp_t;

    exp_t q[$];

    hpdmc_initseq #(.init_wait(IW), .dll_wait(DW)) dut (
        .sys_clk(clk), .sdram_rst_n(rst_n), .init_restart(init_restart),
        .tim_rp(tim_rp), .tim_mrd(tim_mrd), .tim_rfc(tim_rfc), .tim_cas(tim_cas),
        .sched_cs_n(sched_cs_n), .sched_we_n(sched_we_n), .sched_cas_n(sched_cas_n),
        .sched_ras_n(sched_ras_n), .sched_adr(sched_adr), .sched_ba(sched_ba),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_we_n(sdram_we_n),
        .sdram_cas_n(sdram_cas_n), .sdram_ras_n(sdram_ras_n), .sdram_adr(sdram_adr),
        .sdram_ba(sdram_ba), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] mrsw(input bit cas, input bit dll);
        return 13'(2 + (cas ? 3 : 2) * 16 + (dll ? 256 : 0));
    endfunction

    task automatic push_e(input bit cke, input bit dn, input logic [3:0] c, input bit isc,
                          input logic [12:0] a, input logic [1:0] b);
        exp_t e;
        e.cke = cke; e.done = dn; e.cmd = c; e.is_cmd = isc; e.adr = a; e.ba = b;
        q.push_back(e);
    endtask

    task automatic add_cmd(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b, input int n);
        push_e(1, 0, c, 1, a, b);
        repeat (n) push_e(1, 0, C_NOP, 0, '0, '0);
    endtask

    // Expected outputs for every cycle, from the first edge after reset
    // release (or after the restart edge) up to and including init_done = 1.
    task automatic build(input bit from_rst, input int rp, input int mrd, input int rfc, input bit cas);
        q.delete();
        if (from_rst) repeat (IW) push_e(0, 0, C_DESEL, 0, '0, '0);
        push_e(1, 0, C_NOP, 0, '0, '0);
        add_cmd(C_PRE,  13'd1024,      2'd0, rp);
        add_cmd(C_MRS,  13'd0,         2'd1, mrd);
        add_cmd(C_MRS,  mrsw(cas, 1),  2'd0, mrd);
        add_cmd(C_PRE,  13'd1024,      2'd0, rp);
        add_cmd(C_AREF, 13'd0,         2'd0, rfc);
        add_cmd(C_AREF, 13'd0,         2'd0, rfc);
        add_cmd(C_MRS,  mrsw(cas, 0),  2'd0, DW);
        push_e(1, 1, C_NOP, 0, '0, '0);
    endtask

    task automatic follow(input string tag, input int stop_at, input int hold_n, output int r);
        r = -1;
        for (int i = 0; i < q.size() && i < stop_at; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s/c%0d/cke", tag, i), sdram_cke, q[i].cke);
            chk($sformatf("%s/c%0d/done", tag, i), init_done, q[i].done);
            if (!q[i].done)
                chk($sformatf("%s/c%0d/cmd", tag, i),
                    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, q[i].cmd);
            if (q[i].is_cmd) begin
                chk($sformatf("%s/c%0d/adr", tag, i), sdram_adr, q[i].adr);
                chk($sformatf("%s/c%0d/ba", tag, i), sdram_ba, q[i].ba);
            end
            if (init_done === 1'b1 && r < 0) r = i;
            init_restart = (i + 1 < hold_n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/cke"}, sdram_cke, 0);
        chk({tag, "/cmd"}, {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_DESEL);
        chk({tag, "/adr"}, sdram_adr, 0);
        chk({tag, "/ba"}, sdram_ba, 0);
        chk({tag, "/done"}, init_done, 0);
    endtask

    // Called at posedge+1; leaves rst_n released so the next edge is cycle 0.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_sched();
        {sched_cs_n, sched_ras_n, sched_cas_n, sched_we_n} = 4'($urandom);
        sched_adr = 13'($urandom);
        sched_ba  = 2'($urandom);
    endtask

    initial begin
        rand_sched();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Reference timing from the first scenario
        tim_rp = 3'd2; tim_mrd = 2'd1; tim_rfc = 4'd8; tim_cas = 1'b0;
        build(1, 2, 1, 8, 0);
        follow("s1", 1 << 20, 0, rise);
        chk("s1/rise", rise, 246);

        // Pass-through once the scheduler owns the bus
        sched_cs_n = 0; sched_we_n = 1; sched_cas_n = 0; sched_ras_n = 1;
        sched_adr = 13'h0AB; sched_ba = 2'd2;
        #1;
        chk("pt/cmd", {sdram_cs_n, sdram_we_n, sdram_cas_n, sdram_ras_n}, 4'b0101);
        chk("pt/adr", sdram_adr, 13'h0AB);
        chk("pt/ba", sdram_ba, 2);
        for (int k = 0; k < 4; k++) begin
            rand_sched();
            #1;
            chk("ptr/cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                {sched_cs_n, sched_ras_n, sched_cas_n, sched_we_n});
            chk("ptr/adr", sdram_adr, sched_adr);
            chk("ptr/ba", sdram_ba, sched_ba);
        end
        @(posedge clk); #1;

        // Restart with random timings; CKE must stay high throughout
        for (int k = 0; k < 4; k++) begin
            rand_sched();
            tim_rp  = 3'($urandom);
            tim_mrd = 2'($urandom);
            tim_rfc = 4'($urandom);
            tim_cas = (k == 0) ? 1'b1 : 1'($urandom);
            build(0, tim_rp, tim_mrd, tim_rfc, tim_cas);
            init_restart = 1'b1;
            follow($sformatf("rs%0d", k), 1 << 20, 0, rise);
            chk("rs/rise", rise, q.size() - 1);
        end

        // All delays zero, CL3: back-to-back commands from power-up
        rand_sched();
        tim_rp = 0; tim_mrd = 0; tim_rfc = 0; tim_cas = 1'b1;
        do_reset("rst0");
        build(1, 0, 0, 0, 1);
        follow("zero", 1 << 20, 0, rise);
        chk("zero/rise", rise, IW + 1 + 7 + DW);
        chk("zero/mrs_last", q[IW + 7].adr, 13'h032);

        // Reset during AREF1: cycle 27 is AREF1, cut in at cycle 28
        tim_rp = 3'd2; tim_mrd = 2'd1; tim_rfc = 4'd8; tim_cas = 1'b0;
        do_reset("rst1");
        build(1, 2, 1, 8, 0);
        follow("pre_rst", 29, 0, rise);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        follow("post_rst", 1 << 20, 0, rise);
        chk("post_rst/rise", rise, 246);

        // Restart held high throughout the sequence has no effect
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst2");
        init_restart = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        build(1, 2, 1, 8, 0);
        follow("hold", 1 << 20, q.size() - 1, rise);
        chk("hold/rise", rise, 246);
        @(posedge clk); #1;
        chk("hold/stay_done", init_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
